hazard_unit_mc: RTL and testbench

- Next-generation pipeline hazard controller for the 5-stage MIPS core.
- Adds to the existing load-use and branch stall rules, and to EX forwarding:
  - decode-stage branch forwarding;
  - a busy tracker for the multi-cycle multiply/divide unit;
  - a sequenced syscall drain/handshake state machine.
- Sits beside the pipeline registers and drives stall, flush and forward selects for the F, D and E stages.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_unit_mc_muldiv_busy_counter.sv | 37 +++
 rtl/hazard_unit_mc.sv | 125 ++++++++++++
 tb/tb_hazard_unit_mc.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StWaitAck,
    StRelease
  } sys_state_e;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_V0   = 2;
  localparam int unsigned REG_A0   = 4;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/hazard_unit_mc_muldiv_busy_counter.sv
// Busy tracker for the multi-cycle mult/div unit: busy for MD_LATENCY-1 cycles after start.
module muldiv_busy_counter #(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int unsigned CntW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  logic [CntW-1:0] count_q, count_d;

  // A start while busy is illegal but still reloads so the unit's view stays consistent.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = CntW'(MD_LATENCY - 1);
    end else if (count_q != '0) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);

  start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy));

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: stalls, flushes, EX/branch forwarding, mult/div and syscall drain.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MD_LATENCY = 32,
  parameter bit          DRAIN_ALL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             BranchD,
  input  logic             MulDivStartD,
  input  logic             HiLoReadD,
  input  logic             SyscallD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic             MulDivStartE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             MemtoRegM,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  input  logic             SyscallAck,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             SyscallReq,
  output logic             MulDivBusy
);

  localparam logic [REG_W-1:0] RegZero = REG_W'(REG_ZERO);
  localparam logic [REG_W-1:0] RegV0   = REG_W'(REG_V0);
  localparam logic [REG_W-1:0] RegA0   = REG_W'(REG_A0);

  sys_state_e state_q;
  logic       sys_req_q;
  logic       pending_wr;
  logic       lw_stall, branch_stall, md_stall, sys_stall, stall;

  muldiv_busy_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .start(MulDivStartE),
    .busy (MulDivBusy)
  );

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (src != RegZero && src == WriteRegM && RegWriteM) return FWD_M;
    if (src != RegZero && src == WriteRegW && RegWriteW) return FWD_W;
    return FWD_NONE;
  endfunction

  function automatic logic is_sys_reg(input logic [REG_W-1:0] r);
    return DRAIN_ALL || r == RegV0 || r == RegA0;
  endfunction

  always_comb begin
    pending_wr = (RegWriteE && is_sys_reg(WriteRegE)) ||
                 (RegWriteM && is_sys_reg(WriteRegM)) ||
                 (RegWriteW && is_sys_reg(WriteRegW));
  end

  // Register 0 is deliberately not excluded from the stall compares.
  always_comb begin
    lw_stall     = MemtoRegE && (RsD == RtE || RtD == RtE);
    branch_stall = BranchD &&
                   ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                    (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    md_stall     = MulDivBusy && (MulDivStartD || HiLoReadD);
    sys_stall    = (state_q == StDrain) || (state_q == StWaitAck);
    stall        = lw_stall | branch_stall | md_stall | sys_stall;
  end

  assign StallF     = stall;
  assign StallD     = stall;
  assign FlushE     = stall;
  assign ForwardAE  = fwd_sel(RsE);
  assign ForwardBE  = fwd_sel(RtE);
  assign ForwardAD  = RsD != RegZero && RsD == WriteRegM && RegWriteM && !MemtoRegM;
  assign ForwardBD  = RtD != RegZero && RtD == WriteRegM && RegWriteM && !MemtoRegM;
  assign SyscallReq = sys_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sys_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (SyscallD) state_q <= StDrain;
        end
        StDrain: begin
          if (!pending_wr) begin
            state_q   <= StWaitAck;
            sys_req_q <= 1'b1;
          end
        end
        StWaitAck: begin
          if (SyscallAck) begin
            state_q   <= StRelease;
            sys_req_q <= 1'b0;
          end
        end
        // One stall-free cycle lets the syscall move to E; SyscallD here is ignored.
        StRelease: state_q <= StIdle;
        default: begin
          state_q   <= StIdle;
          sys_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (MD_LATENCY=4, DRAIN_ALL=0).
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, MulDivStartD, HiLoReadD, SyscallD;
  logic       MemtoRegE, RegWriteE, MulDivStartE, MemtoRegM, RegWriteM, RegWriteW, SyscallAck;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, SyscallReq, MulDivBusy;
  logic [1:0] ForwardAE, ForwardBE;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .REG_W     (5),
    .MD_LATENCY(4),
    .DRAIN_ALL (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RsD         (RsD),
    .RtD         (RtD),
    .BranchD     (BranchD),
    .MulDivStartD(MulDivStartD),
    .HiLoReadD   (HiLoReadD),
    .SyscallD    (SyscallD),
    .RsE         (RsE),
    .RtE         (RtE),
    .WriteRegE   (WriteRegE),
    .MemtoRegE   (MemtoRegE),
    .RegWriteE   (RegWriteE),
    .MulDivStartE(MulDivStartE),
    .WriteRegM   (WriteRegM),
    .MemtoRegM   (MemtoRegM),
    .RegWriteM   (RegWriteM),
    .WriteRegW   (WriteRegW),
    .RegWriteW   (RegWriteW),
    .SyscallAck  (SyscallAck),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ForwardAD   (ForwardAD),
    .ForwardBD   (ForwardBD),
    .SyscallReq  (SyscallReq),
    .MulDivBusy  (MulDivBusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stl();
    return {29'd0, StallF, StallD, FlushE};
  endfunction

  task automatic clear_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {BranchD, MulDivStartD, HiLoReadD, SyscallD} = '0;
    {MemtoRegE, RegWriteE, MulDivStartE, MemtoRegM, RegWriteM, RegWriteW, SyscallAck} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("reset_stall", stl(), 32'd0);
    chk("reset_sysreq", {31'd0, SyscallReq}, 32'd0);
    chk("reset_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("reset_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
    #11 rst_n = 1'b1;
    tick();

    // Load-use
    MemtoRegE = 1'b1; RtE = 5'd8; RsD = 5'd8; #1;
    chk("lw_stall", stl(), 32'd7);
    tick();
    MemtoRegE = 1'b0; #1;
    chk("lw_release", stl(), 32'd0);
    clear_inputs();

    // EX forwarding priority
    RsE = 5'd9; RtE = 5'd9; WriteRegM = 5'd9; RegWriteM = 1'b1; WriteRegW = 5'd9; RegWriteW = 1'b1;
    #1;
    chk("fwdAE_M_prio", {30'd0, ForwardAE}, 32'd2);
    chk("fwdBE_M_prio", {30'd0, ForwardBE}, 32'd2);
    RegWriteM = 1'b0; #1;
    chk("fwdAE_W", {30'd0, ForwardAE}, 32'd1);
    RegWriteM = 1'b1; RsE = 5'd0; #1;
    chk("fwdAE_r0", {30'd0, ForwardAE}, 32'd0);
    clear_inputs();

    // Branch forwarding / stall
    BranchD = 1'b1; RsD = 5'd5; RtD = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1; #1;
    chk("br_fwdAD", {31'd0, ForwardAD}, 32'd1);
    chk("br_fwdBD", {31'd0, ForwardBD}, 32'd1);
    chk("br_nostall", stl(), 32'd0);
    MemtoRegM = 1'b1; #1;
    chk("br_load_fwdAD", {31'd0, ForwardAD}, 32'd0);
    chk("br_load_stall", stl(), 32'd7);
    MemtoRegM = 1'b0; RegWriteM = 1'b0; RegWriteE = 1'b1; WriteRegE = 5'd5; #1;
    chk("br_E_stall", stl(), 32'd7);
    clear_inputs();
    tick();

    // Mult/div busy window, MD_LATENCY=4
    MulDivStartE = 1'b1; HiLoReadD = 1'b1; #1;
    chk("md_c0_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("md_c0_stall", stl(), 32'd0);
    tick();
    MulDivStartE = 1'b0; #1;
    chk("md_c1_busy", {31'd0, MulDivBusy}, 32'd1);
    chk("md_c1_stall", stl(), 32'd7);
    tick();
    chk("md_c2_stall", stl(), 32'd7);
    tick();
    chk("md_c3_busy", {31'd0, MulDivBusy}, 32'd1);
    tick();
    chk("md_c4_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("md_c4_stall", stl(), 32'd0);
    clear_inputs();
    tick();

    // Syscall drain while v0 write is pending in M
    SyscallD = 1'b1; WriteRegM = 5'd2; RegWriteM = 1'b1; #1;
    chk("sys_idle_nostall", stl(), 32'd0);
    tick();
    chk("sys_drain_stall", stl(), 32'd7);
    chk("sys_drain_noreq", {31'd0, SyscallReq}, 32'd0);
    tick();
    chk("sys_drain_hold", stl(), 32'd7);
    RegWriteM = 1'b0;
    tick();
    chk("sys_wait_req", {31'd0, SyscallReq}, 32'd1);
    chk("sys_wait_stall", stl(), 32'd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sys_wait_hold", {31'd0, SyscallReq}, 32'd1);
    end
    SyscallAck = 1'b1;
    tick();
    SyscallAck = 1'b0; #1;
    chk("sys_release_nostall", stl(), 32'd0);
    chk("sys_release_noreq", {31'd0, SyscallReq}, 32'd0);
    tick();
    SyscallD = 1'b0; #1;
    chk("sys_idle_after", stl(), 32'd0);
    tick();
    chk("sys_no_retrigger", stl(), 32'd0);
    clear_inputs();

    // Reset in WAIT_ACK with mult/div busy
    SyscallD = 1'b1;
    tick();
    SyscallD = 1'b0; MulDivStartE = 1'b1;
    tick();
    MulDivStartE = 1'b0; #1;
    chk("rst_pre_req", {31'd0, SyscallReq}, 32'd1);
    chk("rst_pre_busy", {31'd0, MulDivBusy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", {31'd0, SyscallReq}, 32'd0);
    chk("rst_async_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("rst_async_stall", stl(), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_idle_stall", stl(), 32'd0);
    chk("rst_idle_req", {31'd0, SyscallReq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
